mult_seq_su: RTL

//  Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.

---
 rtl/mult_seq_su.sv | 102 ++++++++++
 1 files changed

// File: rtl/mult_seq_su.sv
// Iterative signed/unsigned shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, valid/ready on both sides.
// Optional MULT_SEQ_ZERO_SKIP_EN: zero operands go straight to DONE with prod=0.
module mult_seq_su #(
   parameter int unsigned WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     x,
   input  logic [WIDTH-1:0]     y,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   prod
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t               state_q, state_d;
   logic                 neg_q, neg_d;
   logic [WIDTH-1:0]     mag_x_q, mag_x_d;
   logic [WIDTH-1:0]     mag_y_q, mag_y_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic [2*WIDTH-1:0]   partial;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign prod      = prod_q;

   always_comb begin
      state_d = state_q;
      neg_d   = neg_q;
      mag_x_d = mag_x_q;
      mag_y_d = mag_y_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      prod_d  = prod_q;
      partial = mag_y_q[cnt_q] ? ({{WIDTH{1'b0}}, mag_x_q} << cnt_q) : '0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               neg_d   = is_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
               // Two's-complement negate of the most-negative value yields 2^(W-1), exact as unsigned.
               mag_x_d = (is_signed && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
               mag_y_d = (is_signed && y[WIDTH-1]) ? (~y + WIDTH'(1)) : y;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = CALC;
`ifdef MULT_SEQ_ZERO_SKIP_EN
               if (x == '0 || y == '0) begin
                  prod_d  = '0;
                  state_d = DONE;
               end
`endif
            end
         end
         CALC: begin
            acc_d = acc_q + partial;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               cnt_d   = '0;
               state_d = FIX;
            end
         end
         FIX: begin
            prod_d  = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         neg_q   <= 1'b0;
         mag_x_q <= '0;
         mag_y_q <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         neg_q   <= neg_d;
         mag_x_q <= mag_x_d;
         mag_y_q <= mag_y_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         prod_q  <= prod_d;
      end
   end

endmodule
